// File: rtl/mem_module.sv
// MEM pipeline stage: stalls upstream while a multi-cycle SRAM load or store
// completes, then hands the instruction to the MEM/WB register.
module mem_module #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic [31:0] ALU_result_IN,
    input  logic [31:0] ST_val_IN,
    input  logic [3:0]  Dest_IN,
    output logic        freeze,
    output logic [15:0] SRAM_ADDR,
    output logic [31:0] SRAM_WDATA,
    input  logic [31:0] SRAM_RDATA,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic [31:0] ALU_result,
    output logic [31:0] MEM_result,
    output logic [3:0]  Dest
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wb_en_q, wb_en_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mem_res_q, mem_res_d;
    logic [3:0]  dest_q, dest_d;

    logic        mem_req;
    logic        is_rd;
    logic        stall;

    // A request with both enables set is a store; only a pure read is a load.
    assign mem_req = MEM_R_EN_IN | MEM_W_EN_IN;
    assign is_rd   = MEM_R_EN_IN & ~MEM_W_EN_IN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    stall   = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    if (is_rd) rdata_d = SRAM_RDATA;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        alu_d      = alu_q;
        mem_res_d  = mem_res_q;
        dest_d     = dest_q;
        if (!stall) begin
            wb_en_d    = WB_EN_IN;
            mem_r_en_d = is_rd;
            alu_d      = ALU_result_IN;
            dest_d     = Dest_IN;
            if (is_rd) mem_res_d = rdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rdata_q    <= 32'd0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_q      <= 32'd0;
            mem_res_q  <= 32'd0;
            dest_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_q      <= alu_d;
            mem_res_q  <= mem_res_d;
            dest_q     <= dest_d;
        end
    end

    // Strobes decode the current state so a reset drops them in the same cycle.
    assign freeze     = rst & stall;
    assign SRAM_WE_N  = ~((state_q == ACCESS) & MEM_W_EN_IN);
    assign SRAM_OE_N  = ~((state_q == ACCESS) & is_rd);
    // (A - 1024)[17:2] equals A[17:2] - 256 because 1024 has no bits below 2.
    assign SRAM_ADDR  = ALU_result_IN[17:2] - 16'd256;
    assign SRAM_WDATA = ST_val_IN;

    assign WB_EN      = wb_en_q;
    assign MEM_R_EN   = mem_r_en_q;
    assign ALU_result = alu_q;
    assign MEM_result = mem_res_q;
    assign Dest       = dest_q;

endmodule

// File: tb/tb_mem_module.sv
// Bench for mem_module: random and directed instruction stream, word-level
// memory reference model and a scoreboard on the MEM/WB register.
module tb_mem_module;

    localparam int WAIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [31:0] ALU_result_IN, ST_val_IN;
    logic [3:0]  Dest_IN;
    logic        freeze;
    logic [15:0] SRAM_ADDR;
    logic [31:0] SRAM_WDATA, SRAM_RDATA;
    logic        SRAM_WE_N, SRAM_OE_N;
    logic        WB_EN, MEM_R_EN;
    logic [31:0] ALU_result, MEM_result;
    logic [3:0]  Dest;

    always #5 clk = ~clk;

    mem_module #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .ALU_result_IN(ALU_result_IN), .ST_val_IN(ST_val_IN), .Dest_IN(Dest_IN),
        .freeze(freeze),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .MEM_result(MEM_result), .Dest(Dest)
    );

    function automatic logic [31:0] dflt(input logic [15:0] a);
        return {a, ~a} ^ 32'hA5C3_0F1E;
    endfunction

    // SRAM device model seen by the DUT
    logic [31:0] sram   [0:65535];
    bit          sram_v [0:65535];
    always @(posedge clk) begin
        if (!SRAM_WE_N) begin
            sram[SRAM_ADDR]   <= SRAM_WDATA;
            sram_v[SRAM_ADDR] <= 1'b1;
        end
    end
    assign SRAM_RDATA = sram_v[SRAM_ADDR] ? sram[SRAM_ADDR] : dflt(SRAM_ADDR);

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mres;
        logic [3:0]  dst;
    } wb_t;

    wb_t         exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] ref_memres = 32'd0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    logic        fz_neg = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    always @(negedge clk) fz_neg <= freeze;

    // Scoreboard monitor: every edge with freeze low loads the MEM/WB register
    initial begin
        forever begin
            @(posedge clk);
            if (mon_en && rst && !fz_neg) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected_load", 32'd1, 32'd0);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("WB_EN", {31'd0, WB_EN}, {31'd0, e.wb});
                    chk("MEM_R_EN", {31'd0, MEM_R_EN}, {31'd0, e.mr});
                    chk("ALU_result", ALU_result, e.alu);
                    chk("MEM_result", MEM_result, e.mres);
                    chk("Dest", {28'd0, Dest}, {28'd0, e.dst});
                end
            end
        end
    end

    task automatic drive(input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] dst);
        WB_EN_IN = wb; MEM_R_EN_IN = r; MEM_W_EN_IN = w;
        ALU_result_IN = alu; ST_val_IN = st; Dest_IN = dst;
    endtask

    // Present one instruction, check its stall/strobe window, return after it is consumed
    task automatic issue(input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] dst);
        logic [15:0] a;
        bit          wr, rd, done;
        int          fcnt, wcnt, ocnt, buserr;
        wb_t         e;
        a  = 16'((alu - 32'd1024) >> 2);
        wr = w;
        rd = r && !w;
        if (wr) ref_mem[int'(a)] = st;
        if (rd) ref_memres = ref_rd(a);
        e = '{wb: wb, mr: rd, alu: alu, mres: ref_memres, dst: dst};
        exp_q.push_back(e);
        drive(wb, r, w, alu, st, dst);
        fcnt = 0; wcnt = 0; ocnt = 0; buserr = 0; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!freeze) begin
                done = 1'b1;
                chk("strobes_idle", {30'd0, SRAM_WE_N, SRAM_OE_N}, 32'd3);
            end else begin
                fcnt++;
                if (!SRAM_WE_N) begin
                    wcnt++;
                    if (SRAM_ADDR !== a || SRAM_WDATA !== st) buserr++;
                end
                if (!SRAM_OE_N) begin
                    ocnt++;
                    if (SRAM_ADDR !== a) buserr++;
                end
            end
        end
        chk("freeze_released", {31'd0, done}, 32'd1);
        chk("freeze_cycles", fcnt, (r || w) ? WAIT + 1 : 0);
        chk("we_cycles", wcnt, wr ? WAIT : 0);
        chk("oe_cycles", ocnt, rd ? WAIT : 0);
        chk("sram_bus", buserr, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd5);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        chk("rst_outs", {WB_EN, MEM_R_EN, Dest, ALU_result | MEM_result}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        issue(1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 4'd2);
        issue(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0);
        issue(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd7);
        issue(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd3);
        issue(1'b0, 1'b0, 1'b1, 32'd1036, 32'h1234_5678, 4'd1);
        issue(1'b1, 1'b1, 1'b1, 32'd1040, 32'hCAFE_F00D, 4'd9);
        issue(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd4);

        for (int i = 0; i < 150; i++) begin
            int          kind;
            logic [31:0] alu;
            kind = $urandom_range(0, 9);
            alu  = 32'd1024 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) alu = $urandom;
            case (kind)
                0, 1, 2, 3: issue(1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
                4, 5, 6:    issue(1'($urandom), 1'b1, 1'b0, alu, $urandom, 4'($urandom));
                7, 8:       issue(1'($urandom), 1'b0, 1'b1, alu, $urandom, 4'($urandom));
                default:    issue(1'($urandom), 1'b1, 1'b1, alu, $urandom, 4'($urandom));
            endcase
        end

        // Abort a store in its second access cycle
        #2;
        mon_en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_pre_we_n", {31'd0, SRAM_WE_N}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("abort_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        chk("abort_freeze", {31'd0, freeze}, 32'd0);
        chk("abort_outs", {WB_EN, MEM_R_EN, Dest, ALU_result | MEM_result}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        // The first access cycle of the aborted store already reached the array
        ref_mem[2] = 32'hDEADBEEF;
        ref_memres = 32'd0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd6);
        issue(1'b1, 1'b0, 1'b0, 32'hABCD, 32'd0, 4'd8);
        issue(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0BAD_F00D, 4'd1);
        issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd2);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_module.md
MEM_MODULE -- requirements
Module: mem_module

Interface
REQ-001 Parameter: WAIT_CYCLES, default 5, number of SRAM access cycles per load or store; legal range 1..15.
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1, asynchronous, active-low reset.
REQ-004 Ports: WB_EN_IN, MEM_R_EN_IN and MEM_W_EN_IN, inputs, 1 each, control bits from the EXE stage register.
REQ-005 Ports: ALU_result_IN and ST_val_IN, inputs, 32 each, the byte address (or ALU value) and the store data.
REQ-006 Port: Dest_IN, input, 4, destination register number.
REQ-007 Port: freeze, output, 1, stall request to all upstream stage registers and PC; high means the upstream stages hold.
REQ-008 Ports to the SRAM:
- SRAM_ADDR, output, 16, word address
- SRAM_WDATA, output, 32, write data
- SRAM_RDATA, input, 32, read data
- SRAM_WE_N, output, 1, active-low write enable
- SRAM_OE_N, output, 1, active-low output enable
REQ-009 Ports to the WB stage: WB_EN, MEM_R_EN, ALU_result, MEM_result and Dest, outputs, widths 1/1/32/32/4, the registered MEM/WB stage values.

Function
REQ-010 SRAM_ADDR SHALL equal bits [17:2] of (ALU_result_IN - 32'd1024); bits [1:0] are ignored (word access only).
REQ-011 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE, plus a 4-bit wait counter cnt.
REQ-012 In IDLE with MEM_R_EN_IN=0 and MEM_W_EN_IN=0:
- freeze=0
- the state stays IDLE
- the instruction passes to the MEM/WB register in 1 cycle.
REQ-013 In IDLE with MEM_R_EN_IN=1 or MEM_W_EN_IN=1:
- freeze SHALL be 1 combinationally in the same cycle
- next state is ACCESS, with cnt=0.
REQ-014 In ACCESS:
- freeze=1
- SRAM_ADDR and SRAM_WDATA are driven from the inputs
- for a write, SRAM_WE_N=0 and SRAM_OE_N=1; for a read, SRAM_WE_N=1 and SRAM_OE_N=0
- cnt increments each cycle.
REQ-015 In ACCESS with cnt==WAIT_CYCLES-1:
- a read SHALL capture SRAM_RDATA into an internal data register
- next state is DONE.
REQ-016 In DONE:
- freeze=0, SRAM_WE_N=1, SRAM_OE_N=1
- next state is IDLE unconditionally, so the held instruction is never re-issued.
REQ-017 For a memory access, freeze SHALL be high for exactly WAIT_CYCLES+1 consecutive cycles.
REQ-018 For a memory access, the MEM/WB register SHALL load on the rising edge that ends DONE.
REQ-019 If MEM_R_EN_IN and MEM_W_EN_IN are both 1, the access SHALL be treated as a write, and MEM_result SHALL not update.
REQ-020 The MEM/WB register SHALL load on every edge where freeze=0 and hold on every edge where freeze=1.
REQ-021 MEM_result SHALL be the captured read data for loads and SHALL retain its previous value otherwise.
REQ-022 The stage SHALL support back-to-back memory instructions: the instruction after DONE is sampled in IDLE on the next cycle and starts a new access.
REQ-023 A store SHALL forward WB_EN=0 only if WB_EN_IN=0; WB_EN SHALL always copy WB_EN_IN unmodified.

Reset
REQ-024 When rst=0, asynchronously:
- state=IDLE and cnt=0
- freeze=0, SRAM_WE_N=1, SRAM_OE_N=1
- WB_EN=0, MEM_R_EN=0, ALU_result=0, MEM_result=0, Dest=0.
REQ-025 A reset asserted mid-access SHALL abort the access immediately with no partial write commit beyond the current cycle.
REQ-026 After a mid-access reset, the first post-reset cycle SHALL be IDLE.

Verification
REQ-027 Use WAIT_CYCLES=3. Non-memory instruction: ALU_result_IN=0x55, WB_EN_IN=1, Dest_IN=2 -> freeze stays 0; the next edge gives ALU_result=0x55, WB_EN=1, Dest=2.
REQ-028 Store: ALU_result_IN=1032, ST_val_IN=0xDEADBEEF -> freeze high for 4 cycles; SRAM_ADDR=2; SRAM_WE_N=0 for 3 cycles; SRAM_WDATA=0xDEADBEEF.
REQ-029 Load from the same address: SRAM model returns 0xDEADBEEF -> freeze high for 4 cycles; after DONE, MEM_result=0xDEADBEEF and MEM_R_EN=1.
REQ-030 Back-to-back load then store -> two freeze windows of 4 cycles each, separated by exactly one freeze=0 cycle (DONE); no duplicate SRAM write.
REQ-031 Reset low during the 2nd ACCESS cycle of a store -> SRAM_WE_N=1 and freeze=0 immediately; all outputs 0; state IDLE after release.
REQ-032 MEM_R_EN_IN=1 and MEM_W_EN_IN=1 together -> write performed; SRAM_OE_N stays 1; MEM_result unchanged.
